// File: rtl/sel_arbiter_pkg.sv
// Shared arbiter definitions: state encoding, mux select constants, counter width.
// Also imported wherever the downstream A/B mux is instantiated.
package sel_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GNT_A = 2'b01,
        ST_GNT_B = 2'b10
    } arb_state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    localparam int CNT_W = 8;

    // Mux select implied by a state; IDLE keeps whatever was selected before.
    function automatic logic sel_of(input arb_state_t state, input logic prev_sel);
        case (state)
            ST_GNT_A: sel_of = SEL_A;
            ST_GNT_B: sel_of = SEL_B;
            default:  sel_of = prev_sel;
        endcase
    endfunction

endpackage

// File: rtl/sel_arbiter_burst_counter.sv
// Beat counter for one grant: synchronous clear, increment, and a
// terminal-count flag raised when the count reaches BURST-1.
module burst_counter
    import sel_arbiter_pkg::*;
#(
    parameter int BURST = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_tc
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(BURST - 1);

    logic [CNT_W-1:0] r_cnt;

    // NOTE: registers are written with <= so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_tc = (r_cnt == TC_VAL);

endmodule

// File: rtl/sel_arbiter.sv
// Two-source burst arbiter: grants A or B for up to BURST beats, alternating
// on ties, and drives a registered select for the downstream mux.
module sel_arbiter
    import sel_arbiter_pkg::*;
#(
    parameter int BURST = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic A_VALID,
    output logic A_READY,
    input  logic B_VALID,
    output logic B_READY,
    output logic OUT_VALID,
    input  logic OUT_READY,
    output logic SEL,
    output logic BUSY
);

    arb_state_t r_state;
    arb_state_t w_next;
    logic       r_sel;
    logic       r_last;
    logic       w_xfer;
    logic       w_tc;
    logic       w_clr;

    // State register; LAST resets to B so A wins the first tie.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_sel   <= SEL_A;
            r_last  <= SEL_B;
        end else begin
            r_state <= w_next;
            r_sel   <= sel_of(w_next, r_sel);
            r_last  <= sel_of(w_next, r_last);
        end
    end

    // NOTE: w_next gets a default first so no path through the case infers a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (A_VALID && B_VALID) begin
                    w_next = (r_last == SEL_A) ? ST_GNT_B : ST_GNT_A;
                end else if (A_VALID) begin
                    w_next = ST_GNT_A;
                end else if (B_VALID) begin
                    w_next = ST_GNT_B;
                end
            end
            ST_GNT_A: begin
                if (!A_VALID) begin
                    w_next = ST_IDLE;
                end else if (w_xfer && w_tc) begin
                    w_next = B_VALID ? ST_GNT_B : ST_IDLE;
                end
            end
            ST_GNT_B: begin
                if (!B_VALID) begin
                    w_next = ST_IDLE;
                end else if (w_xfer && w_tc) begin
                    w_next = A_VALID ? ST_GNT_A : ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        A_READY   = 1'b0;
        B_READY   = 1'b0;
        OUT_VALID = 1'b0;
        case (r_state)
            ST_GNT_A: begin
                A_READY   = OUT_READY;
                OUT_VALID = A_VALID;
            end
            ST_GNT_B: begin
                B_READY   = OUT_READY;
                OUT_VALID = B_VALID;
            end
            default: ;
        endcase
    end

    assign SEL    = r_sel;
    assign BUSY   = (r_state != ST_IDLE);
    assign w_xfer = OUT_VALID && OUT_READY;
    // Any state change ends the current grant or starts a new one.
    assign w_clr  = (w_next != r_state);

    burst_counter #(
        .BURST (BURST)
    ) u_burst_counter (
        .i_clk (CLK),
        .i_rst (RST),
        .i_clr (w_clr),
        .i_inc (w_xfer),
        .o_tc  (w_tc)
    );

endmodule

// File: tb/tb_sel_arbiter.sv
// Bench for sel_arbiter: BURST=4 and BURST=1 instances share stimulus and are
// checked every cycle against an owner/beats-left model plus literal pins.
module tb_sel_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a_valid = 1'b0;
    logic b_valid = 1'b0;
    logic out_ready = 1'b0;
    logic chk_en = 1'b0;

    logic a_ready4, b_ready4, out_valid4, sel4, busy4;
    logic a_ready1, b_ready1, out_valid1, sel1, busy1;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    sel_arbiter #(.BURST(4)) dut4 (
        .CLK(clk), .RST(rst),
        .A_VALID(a_valid), .A_READY(a_ready4),
        .B_VALID(b_valid), .B_READY(b_ready4),
        .OUT_VALID(out_valid4), .OUT_READY(out_ready),
        .SEL(sel4), .BUSY(busy4)
    );

    sel_arbiter #(.BURST(1)) dut1 (
        .CLK(clk), .RST(rst),
        .A_VALID(a_valid), .A_READY(a_ready1),
        .B_VALID(b_valid), .B_READY(b_ready1),
        .OUT_VALID(out_valid1), .OUT_READY(out_ready),
        .SEL(sel1), .BUSY(busy1)
    );

    // Model: who owns the output (0 none, 1 A, 2 B), beats left in the grant,
    // who was granted most recently, and the mux select.
    typedef struct {
        int owner;
        int left;
        int prev;
        bit sel;
    } mdl_t;

    mdl_t m4 = '{owner: 0, left: 0, prev: 2, sel: 1'b0};
    mdl_t m1 = '{owner: 0, left: 0, prev: 2, sel: 1'b0};

    function automatic mdl_t grant_to(input mdl_t m, input int who, input int burst);
        mdl_t r = m;
        r.owner = who;
        r.prev  = who;
        r.sel   = (who == 2);
        r.left  = burst;
        return r;
    endfunction

    function automatic mdl_t mdl_step(input mdl_t m, input int burst, input bit r,
                                      input bit a, input bit b, input bit rdy);
        mdl_t n = m;
        bit mine, other;
        if (r) begin
            n = '{owner: 0, left: 0, prev: 2, sel: 1'b0};
        end else if (m.owner == 0) begin
            if (a && b)  n = grant_to(m, (m.prev == 1) ? 2 : 1, burst);
            else if (a)  n = grant_to(m, 1, burst);
            else if (b)  n = grant_to(m, 2, burst);
        end else begin
            mine  = (m.owner == 1) ? a : b;
            other = (m.owner == 1) ? b : a;
            if (!mine) begin
                n.owner = 0;
            end else if (rdy) begin
                n.left = m.left - 1;
                if (n.left == 0) begin
                    if (other) n = grant_to(m, 3 - m.owner, burst);
                    else       n.owner = 0;
                end
            end
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m4 = mdl_step(m4, 4, rst, a_valid, b_valid, out_ready);
        m1 = mdl_step(m1, 1, rst, a_valid, b_valid, out_ready);
    end

    task automatic check(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    task automatic compare_outputs(input string tag, input mdl_t m, input logic sel,
                                   input logic busy, input logic ov,
                                   input logic ar, input logic br);
        check({tag, ".sel"},       sel,  m.sel);
        check({tag, ".busy"},      busy, m.owner != 0);
        check({tag, ".out_valid"}, ov,   (m.owner == 1 && a_valid) || (m.owner == 2 && b_valid));
        check({tag, ".a_ready"},   ar,   m.owner == 1 && out_ready);
        check({tag, ".b_ready"},   br,   m.owner == 2 && out_ready);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            compare_outputs("burst4", m4, sel4, busy4, out_valid4, a_ready4, b_ready4);
            compare_outputs("burst1", m1, sel1, busy1, out_valid1, a_ready1, b_ready1);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with both sources already valid.
        rst = 1'b1; a_valid = 1'b1; b_valid = 1'b1; out_ready = 1'b1;
        cyc(2);
        chk_en = 1'b1;
        check("rst.busy4", busy4, 1'b0);
        check("rst.ovalid4", out_valid4, 1'b0);
        check("rst.sel4", sel4, 1'b0);
        check("rst.busy1", busy1, 1'b0);

        // Both valid: A first, 4 beats, then B for 4, then A again.
        rst = 1'b0;
        cyc(1);
        check("tie.first_a.sel4", sel4, 1'b0);
        check("tie.first_a.ardy4", a_ready4, 1'b1);
        check("tie.first_a.sel1", sel1, 1'b0);
        cyc(1);
        check("alt.b.sel1", sel1, 1'b1);
        check("burst.still_a.sel4", sel4, 1'b0);
        cyc(3);
        check("burst.to_b.sel4", sel4, 1'b1);
        check("burst.to_b.brdy4", b_ready4, 1'b1);
        check("burst.to_b.ardy4", a_ready4, 1'b0);
        cyc(4);
        check("burst.back_a.sel4", sel4, 1'b0);

        // Granted A drops valid while B waits: one idle bubble, then B.
        a_valid = 1'b0;
        cyc(1);
        check("drop.bubble.busy4", busy4, 1'b0);
        check("drop.bubble.busy1", busy1, 1'b0);
        cyc(1);
        check("drop.gnt_b.sel4", sel4, 1'b1);
        check("drop.gnt_b.sel1", sel1, 1'b1);

        // Only B valid: 4 beats, one idle cycle, re-granted to B.
        cyc(4);
        check("onlyb.idle.busy4", busy4, 1'b0);
        check("onlyb.idle.sel4", sel4, 1'b1);
        cyc(1);
        check("onlyb.regrant.brdy4", b_ready4, 1'b1);

        // Stall in GNT_A with two beats already taken.
        rst = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(3);
        out_ready = 1'b0;
        cyc(5);
        check("stall.sel4", sel4, 1'b0);
        check("stall.ovalid4", out_valid4, 1'b1);
        check("stall.ardy4", a_ready4, 1'b0);
        check("stall.busy4", busy4, 1'b1);
        out_ready = 1'b1;
        cyc(1);
        check("stall.release.sel4", sel4, 1'b0);
        cyc(1);
        check("stall.switch.sel4", sel4, 1'b1);

        // Reset mid-burst in GNT_B with three beats taken.
        cyc(3);
        rst = 1'b1;
        cyc(1);
        check("midrst.busy4", busy4, 1'b0);
        check("midrst.sel4", sel4, 1'b0);
        check("midrst.ovalid4", out_valid4, 1'b0);
        rst = 1'b0;
        cyc(1);
        check("midrst.first_a.ardy4", a_ready4, 1'b1);
        check("midrst.first_a.sel4", sel4, 1'b0);

        // BURST=1 alternates on every transfer.
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            check("alt.sel1", sel1, (i % 2) == 0);
            check("alt.ardy1", a_ready1, (i % 2) != 0);
        end

        // Non-granted A toggling during B's burst changes nothing.
        a_valid = 1'b0;
        cyc(1);
        check("nongrant.hold.sel4", sel4, 1'b1);
        check("nongrant.hold.brdy4", b_ready4, 1'b1);
        a_valid = 1'b1;
        cyc(1);
        check("nongrant.switch.sel4", sel4, 1'b0);

        // Mixed traffic with stalls, drops and occasional resets.
        for (int i = 0; i < 400; i++) begin
            a_valid   = ($urandom_range(0, 3) != 0);
            b_valid   = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 63) == 0);
            cyc(1);
        end
        rst = 1'b0;
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/sel_arbiter.md
SEL_ARBITER -- requirements
Module: sel_arbiter

Interface
REQ-001 Parameter BURST, default 4, max consecutive transfers granted to one source before re-arbitration; legal range 1..255.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, synchronous and active-high.
REQ-004 A_VALID  input  1  source A has a beat; held high until its transfer.
REQ-005 A_READY  output  1  beat from source A accepted this cycle.
REQ-006 B_VALID  input  1  source B has a beat; held high until its transfer.
REQ-007 B_READY  output  1  beat from source B accepted this cycle.
REQ-008 OUT_VALID  output  1  granted source has a beat on the downstream mux output.
REQ-009 OUT_READY  input  1  downstream accepts the beat.
REQ-010 SEL  output  1  registered select for the downstream mux; 0 = A, 1 = B.
REQ-011 BUSY  output  1  high when state is not IDLE.

Function
REQ-012 States SHALL be IDLE, GNT_A and GNT_B, held in a register.
REQ-013 SEL SHALL be 0 in GNT_A and 1 in GNT_B, and SHALL keep its last value in IDLE; it SHALL never take X or change except on a state transition.
REQ-014 OUT_VALID SHALL be (GNT_A and A_VALID) or (GNT_B and B_VALID), derived combinationally from registered state.
REQ-015 A_READY SHALL be GNT_A and OUT_READY; B_READY SHALL be GNT_B and OUT_READY; they are never high together.
REQ-016 A transfer SHALL occur in a cycle where OUT_VALID and OUT_READY are both high.
REQ-017 IDLE, both valid: the next state SHALL be the grant for the source not served last (register LAST).
REQ-018 IDLE, one valid: the next state SHALL be that source's grant; neither valid: stay in IDLE.
REQ-019 Entering GNT_x SHALL set LAST to x and clear beat counter CNT.
REQ-020 GNT_x with transfer and CNT < BURST-1 SHALL increment CNT and stay in GNT_x.
REQ-021 GNT_x with transfer and CNT = BURST-1: if the other source is valid, go to the other grant; otherwise go to IDLE. CNT clears in either case.
REQ-022 GNT_x with x_VALID low SHALL go to IDLE next cycle (one bubble cycle).
REQ-023 GNT_x with x_VALID high and OUT_READY low (stall) SHALL hold state, CNT and SEL unchanged.
REQ-024 A grant SHALL first be usable in the cycle after the arbitration decision (one-cycle grant latency from IDLE).
REQ-025 With BURST=1, every transfer SHALL trigger re-arbitration (strict alternation when both sources are valid).
REQ-026 Source valid changes in a non-granted source SHALL have no effect until re-arbitration.

Reset
REQ-027 While RST is high at a clock edge: state IDLE, SEL 0, CNT 0, LAST = B (so A wins the first tie).
REQ-028 While RST is high, OUT_VALID, A_READY, B_READY and BUSY SHALL be 0 in the cycle after the edge.
REQ-029 RST mid-burst or during a stall SHALL take priority over every transition; the pending beat is not counted.

Structure
REQ-030 The state encoding (IDLE/GNT_A/GNT_B) and the SEL_A=0 / SEL_B=1 constants SHALL live in a shared package also used by the mux instantiation site.
REQ-031 The beat counter SHALL be a sub-module burst_counter (clear, increment, terminal-count output at BURST-1; width 8 bits).

Verification
REQ-032 Reset with A_VALID=B_VALID=1, BURST=4, OUT_READY=1 -> state GNT_A, SEL=0; 4 A transfers, then GNT_B, SEL=1; 4 B transfers; then back to A.
REQ-033 Only B_VALID=1, OUT_READY=1, BURST=4 -> 4 B transfers, one IDLE cycle, then re-grant to B; A_READY stays 0 throughout.
REQ-034 In GNT_A with CNT=2, hold OUT_READY=0 for 5 cycles -> SEL, CNT and A_VALID are held; after release, 2 more A transfers, then switch to B.
REQ-035 BURST=1, both valid, OUT_READY=1 -> SEL toggles on every transfer; transfers alternate A, B, A, B.
REQ-036 Assert RST in GNT_B with CNT=3 -> next cycle IDLE, SEL=0, OUT_VALID=0; with both valid afterwards, A is granted first.
REQ-037 In GNT_A, drop A_VALID while B_VALID=1 -> one IDLE cycle, then GNT_B with SEL=1.
